wb_rr_arbiter3: RTL and testbench
=================================

WB_RR_ARBITER3 -- requirements
Module: wb_rr_arbiter3

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, meaning Wishbone address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles a strobed transfer may wait for slave ack/err/rty (range 2..255).
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 wbN_cyc, wbN_stb, wbN_we, wbN_4_burst, wbN_8_burst  input  1 each  master N requests, N=0..2.
REQ-006 wbN_adr  input  ADDR_W; wbN_o_dat  input  16; wbN_sel  input  2  master N address, write data and byte select.
REQ-007 wbN_ack, wbN_err, wbN_rty  output  1 each  responses routed to master N.
REQ-008 owb_cyc, owb_stb, owb_we, owb_4_burst, owb_8_burst  output  1; owb_adr  output  ADDR_W; owb_o_dat  output  16; owb_sel  output  2  slave side.
REQ-009 owb_ack, owb_err, owb_rty  input  1  slave responses.
REQ-010 o_grant  output  2  index of the owning master, 3 = none.
REQ-011 o_timeout  output  1  one-cycle pulse on transfer abort.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT and ABORT.
REQ-013 IDLE: when any wbN_cyc=1, SHALL register the winner and enter GRANT next cycle; otherwise stay.
REQ-014 Winner SHALL be chosen round-robin: search starts at index ptr, ascending, wrapping 2->0; ptr resets to 0.
REQ-015 On entering GRANT with master g, ptr SHALL become (g+1) mod 3.
REQ-016 In GRANT, owb_cyc SHALL equal wbg_cyc, and owb_stb/we/adr/o_dat/sel/4_burst/8_burst SHALL be combinational copies of master g's signals.
REQ-017 In GRANT, wbg_ack/err/rty SHALL be combinational copies of owb_ack/err/rty; all other masters' responses SHALL be 0.
REQ-018 In IDLE and ABORT, owb_cyc, owb_stb and all wbN_ack/rty SHALL be 0; o_grant SHALL be 3 in IDLE.
REQ-019 Grant SHALL be held while wbg_cyc=1, including across multiple strobes and 4/8-beat bursts; requests from other masters SHALL NOT preempt.
REQ-020 When wbg_cyc=0 in GRANT, the FSM SHALL return to IDLE; exactly one idle cycle (owb_cyc=0) SHALL separate consecutive owners.
REQ-021 An 8-bit wait counter SHALL reset to 0 in IDLE, and on any cycle with owb_stb=0 or owb_ack|owb_err|owb_rty=1; otherwise it SHALL increment.
REQ-022 When the counter equals TIMEOUT while in GRANT with owb_stb=1 and no response, the FSM SHALL enter ABORT next cycle.
REQ-023 On the first ABORT cycle, wbg_err and o_timeout SHALL pulse for exactly one cycle.
REQ-024 ABORT SHALL persist until wbg_cyc=0, then go to IDLE.
REQ-025 Simultaneous owner release and new requests: the release cycle goes to IDLE; arbitration happens in that IDLE cycle using the updated ptr.
REQ-026 A response arriving on the same cycle the counter reaches TIMEOUT SHALL win: it is forwarded and no abort occurs.

Reset
REQ-027 While i_rst_n=0: state IDLE, ptr 0, counter 0, o_grant 3, all owb_* and wbN_ack/err/rty and o_timeout 0.
REQ-028 Reset assertion mid-transfer SHALL drop owb_cyc immediately (asynchronously); after release, arbitration restarts from ptr 0.

Verification
REQ-029 All three cyc raised together from reset -> grants in order 0,1,2,0, each followed by one idle cycle; o_grant sequence 0,3,1,3,2,3,0.
REQ-030 Master 1 holds cyc through an 8-beat burst while masters 0 and 2 request -> 8 acks reach wb1_ack only, wb0_ack=wb2_ack=0 throughout, no handoff until wb1_cyc falls.
REQ-031 TIMEOUT=4, master 2 strobes, slave never acks -> ABORT entered after the counter reaches 4, wb2_err and o_timeout high for exactly one cycle, owb_cyc=0 until wb2_cyc falls.
REQ-032 Slave ack on the exact cycle the counter equals TIMEOUT -> ack forwarded, no err, o_timeout stays 0.
REQ-033 i_rst_n pulled low while master 0 owns the bus -> owb_cyc=0 within the same cycle, o_grant=3; after release with only master 2 requesting, master 2 is granted.
REQ-034 Slave err/rty during GRANT -> routed only to the owner, grant retained while its cyc=1.

Source files
------------

// File: rtl/wb_rr_arbiter3.sv
// Three-master Wishbone round-robin arbiter with a per-strobe wait timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | bus free, no owner; picks the next requester round-robin
// ST_GRANT | owner g drives the slave port and receives its responses
// ST_ABORT | slave timed out; err pulsed once, bus held off until g drops cyc
module wb_rr_arbiter3 #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              wb0_cyc,
    input  logic              wb0_stb,
    input  logic              wb0_we,
    input  logic              wb0_4_burst,
    input  logic              wb0_8_burst,
    input  logic [ADDR_W-1:0] wb0_adr,
    input  logic [15:0]       wb0_o_dat,
    input  logic [1:0]        wb0_sel,
    output logic              wb0_ack,
    output logic              wb0_err,
    output logic              wb0_rty,
    input  logic              wb1_cyc,
    input  logic              wb1_stb,
    input  logic              wb1_we,
    input  logic              wb1_4_burst,
    input  logic              wb1_8_burst,
    input  logic [ADDR_W-1:0] wb1_adr,
    input  logic [15:0]       wb1_o_dat,
    input  logic [1:0]        wb1_sel,
    output logic              wb1_ack,
    output logic              wb1_err,
    output logic              wb1_rty,
    input  logic              wb2_cyc,
    input  logic              wb2_stb,
    input  logic              wb2_we,
    input  logic              wb2_4_burst,
    input  logic              wb2_8_burst,
    input  logic [ADDR_W-1:0] wb2_adr,
    input  logic [15:0]       wb2_o_dat,
    input  logic [1:0]        wb2_sel,
    output logic              wb2_ack,
    output logic              wb2_err,
    output logic              wb2_rty,
    output logic              owb_cyc,
    output logic              owb_stb,
    output logic              owb_we,
    output logic              owb_4_burst,
    output logic              owb_8_burst,
    output logic [ADDR_W-1:0] owb_adr,
    output logic [15:0]       owb_o_dat,
    output logic [1:0]        owb_sel,
    input  logic              owb_ack,
    input  logic              owb_err,
    input  logic              owb_rty,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              to_q, to_d;

    logic [2:0]        cyc_v;
    logic [1:0]        ptr_p1, ptr_p2, win;
    logic              in_grant, resp;
    logic              m_cyc, m_stb, m_we, m_b4, m_b8;
    logic [ADDR_W-1:0] m_adr;
    logic [15:0]       m_dat;
    logic [1:0]        m_sel;

    assign cyc_v    = {wb2_cyc, wb1_cyc, wb0_cyc};
    assign in_grant = (state_q == ST_GRANT);
    assign resp     = owb_ack | owb_err | owb_rty;

    // Round-robin pick: first requester at or after ptr, wrapping 2 -> 0.
    always_comb begin
        ptr_p1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        ptr_p2 = (ptr_p1 == 2'd2) ? 2'd0 : ptr_p1 + 2'd1;
        win    = ptr_q;
        if (cyc_v[ptr_q])       win = ptr_q;
        else if (cyc_v[ptr_p1]) win = ptr_p1;
        else if (cyc_v[ptr_p2]) win = ptr_p2;
    end

    // Select the current owner's request signals.
    always_comb begin
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
        m_b4  = 1'b0;
        m_b8  = 1'b0;
        m_adr = '0;
        m_dat = '0;
        m_sel = '0;
        case (grant_q)
            2'd0: begin
                m_cyc = wb0_cyc; m_stb = wb0_stb; m_we = wb0_we;
                m_b4 = wb0_4_burst; m_b8 = wb0_8_burst;
                m_adr = wb0_adr; m_dat = wb0_o_dat; m_sel = wb0_sel;
            end
            2'd1: begin
                m_cyc = wb1_cyc; m_stb = wb1_stb; m_we = wb1_we;
                m_b4 = wb1_4_burst; m_b8 = wb1_8_burst;
                m_adr = wb1_adr; m_dat = wb1_o_dat; m_sel = wb1_sel;
            end
            2'd2: begin
                m_cyc = wb2_cyc; m_stb = wb2_stb; m_we = wb2_we;
                m_b4 = wb2_4_burst; m_b8 = wb2_8_burst;
                m_adr = wb2_adr; m_dat = wb2_o_dat; m_sel = wb2_sel;
            end
            default: ;
        endcase
    end

    // Slave-side drive and response routing; everything is gated by state so
    // an async reset drops the bus without waiting for a clock edge.
    always_comb begin
        owb_cyc     = in_grant & m_cyc;
        owb_stb     = in_grant & m_stb;
        owb_we      = in_grant & m_we;
        owb_4_burst = in_grant & m_b4;
        owb_8_burst = in_grant & m_b8;
        owb_adr     = in_grant ? m_adr : '0;
        owb_o_dat   = in_grant ? m_dat : '0;
        owb_sel     = in_grant ? m_sel : '0;
        wb0_ack = 1'b0; wb0_err = 1'b0; wb0_rty = 1'b0;
        wb1_ack = 1'b0; wb1_err = 1'b0; wb1_rty = 1'b0;
        wb2_ack = 1'b0; wb2_err = 1'b0; wb2_rty = 1'b0;
        case (grant_q)
            2'd0: begin
                wb0_ack = in_grant & owb_ack;
                wb0_err = (in_grant & owb_err) | to_q;
                wb0_rty = in_grant & owb_rty;
            end
            2'd1: begin
                wb1_ack = in_grant & owb_ack;
                wb1_err = (in_grant & owb_err) | to_q;
                wb1_rty = in_grant & owb_rty;
            end
            2'd2: begin
                wb2_ack = in_grant & owb_ack;
                wb2_err = (in_grant & owb_err) | to_q;
                wb2_rty = in_grant & owb_rty;
            end
            default: ;
        endcase
        o_grant   = (state_q == ST_IDLE) ? 2'd3 : grant_q;
        o_timeout = to_q;
    end

    // Next-state, pointer and wait-counter logic. A response on the
    // terminal-count cycle blocks the abort because resp is checked first.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        to_d    = 1'b0;
        cnt_d   = (state_q == ST_IDLE || !owb_stb || resp) ? 8'd0 : cnt_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                if (|cyc_v) begin
                    grant_d = win;
                    ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!m_cyc) begin
                    state_d = ST_IDLE;
                end else if (m_stb && !resp && cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_ABORT;
                    to_d    = 1'b1;
                end
            end
            ST_ABORT: begin
                if (!m_cyc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter3.sv
module tb_wb_rr_arbiter3;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cyc, stb, we, b4, b8;
    logic [23:0] adr [3];
    logic [15:0] dat [3];
    logic [1:0]  sel [3];
    logic [2:0]  ack_o, err_o, rty_o;
    logic        owb_cyc, owb_stb, owb_we, owb_4_burst, owb_8_burst;
    logic [23:0] owb_adr;
    logic [15:0] owb_o_dat;
    logic [1:0]  owb_sel;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: owner (-1 = nobody), pointer, wait count, abort flags
    int m_owner, m_ptr, m_wait;
    bit m_abort, m_pulse;
    logic [1:0] e_grant;
    logic       e_cyc, e_stb, e_to;
    logic [2:0] e_ack, e_err, e_rty;

    always #5 clk = ~clk;

    wb_rr_arbiter3 #(.ADDR_W(24), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .wb0_cyc(cyc[0]), .wb0_stb(stb[0]), .wb0_we(we[0]), .wb0_4_burst(b4[0]), .wb0_8_burst(b8[0]),
        .wb0_adr(adr[0]), .wb0_o_dat(dat[0]), .wb0_sel(sel[0]),
        .wb0_ack(ack_o[0]), .wb0_err(err_o[0]), .wb0_rty(rty_o[0]),
        .wb1_cyc(cyc[1]), .wb1_stb(stb[1]), .wb1_we(we[1]), .wb1_4_burst(b4[1]), .wb1_8_burst(b8[1]),
        .wb1_adr(adr[1]), .wb1_o_dat(dat[1]), .wb1_sel(sel[1]),
        .wb1_ack(ack_o[1]), .wb1_err(err_o[1]), .wb1_rty(rty_o[1]),
        .wb2_cyc(cyc[2]), .wb2_stb(stb[2]), .wb2_we(we[2]), .wb2_4_burst(b4[2]), .wb2_8_burst(b8[2]),
        .wb2_adr(adr[2]), .wb2_o_dat(dat[2]), .wb2_sel(sel[2]),
        .wb2_ack(ack_o[2]), .wb2_err(err_o[2]), .wb2_rty(rty_o[2]),
        .owb_cyc(owb_cyc), .owb_stb(owb_stb), .owb_we(owb_we),
        .owb_4_burst(owb_4_burst), .owb_8_burst(owb_8_burst),
        .owb_adr(owb_adr), .owb_o_dat(owb_o_dat), .owb_sel(owb_sel),
        .owb_ack(s_ack), .owb_err(s_err), .owb_rty(s_rty),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    function automatic void model_reset();
        m_owner = -1; m_ptr = 0; m_wait = 0; m_abort = 0; m_pulse = 0;
    endfunction

    function automatic void model_expect();
        int own;
        bit live;
        own     = (m_owner < 0) ? 0 : m_owner;
        live    = (m_owner >= 0) && !m_abort;
        e_grant = (m_owner < 0) ? 2'd3 : 2'(m_owner);
        e_cyc   = live && cyc[own];
        e_stb   = live && stb[own];
        e_ack = '0; e_err = '0; e_rty = '0;
        if (live) begin
            e_ack[own] = s_ack; e_err[own] = s_err; e_rty[own] = s_rty;
        end
        if (m_pulse) e_err[own] = 1'b1;
        e_to = m_pulse;
    endfunction

    function automatic void model_step();
        bit resp;
        int n;
        resp    = s_ack | s_err | s_rty;
        m_pulse = 0;
        if (m_owner < 0) begin
            m_wait = 0;
            for (int k = 0; k < 3; k++) begin
                n = (m_ptr + k) % 3;
                if (m_owner < 0 && cyc[n]) begin
                    m_owner = n;
                    m_ptr   = (n + 1) % 3;
                end
            end
        end else if (m_abort) begin
            if (!cyc[m_owner]) begin m_owner = -1; m_abort = 0; end
        end else if (!cyc[m_owner]) begin
            m_owner = -1; m_wait = 0;
        end else if (stb[m_owner] && !resp && m_wait == TO) begin
            m_abort = 1; m_pulse = 1; m_wait = 0;
        end else begin
            m_wait = (stb[m_owner] && !resp) ? m_wait + 1 : 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0; b4 = '0; b8 = '0;
        s_ack = 0; s_err = 0; s_rty = 0;
        for (int i = 0; i < 3; i++) begin
            adr[i] = 24'($urandom); dat[i] = 16'($urandom); sel[i] = 2'($urandom);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        cyc = 3'b111; stb = 3'b111; s_ack = 1; s_err = 1; s_rty = 1;
        repeat (2) @(negedge clk);
        n_checks++; if (o_grant !== 2'd3) begin n_fail++; $display("FAIL reset_grant: got %0d expected 3", o_grant); end
        n_checks++; if (owb_cyc !== 1'b0 || owb_stb !== 1'b0) begin n_fail++; $display("FAIL reset_owb: cyc=%b stb=%b expected 0 0", owb_cyc, owb_stb); end
        n_checks++; if (ack_o !== 3'b0 || rty_o !== 3'b0) begin n_fail++; $display("FAIL reset_ack_rty: ack=%b rty=%b expected 000 000", ack_o, rty_o); end
        n_checks++; if (err_o !== 3'b0 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_to: err=%b to=%b expected 000 0", err_o, o_timeout); end
    endtask

    task automatic test_rr_order();
        int seq[$];
        int exp_seq[7] = '{0, 3, 1, 3, 2, 3, 0};
        int last, held, drop_g, restore_g, g;
        bit pend;
        last = -1; held = 0; drop_g = -1; restore_g = -1; pend = 0;
        do_reset();
        cyc = 3'b111;
        for (int c = 0; c < 40 && seq.size() < 7; c++) begin
            @(negedge clk);
            model_expect();
            n_checks++; if (o_grant !== e_grant || owb_cyc !== e_cyc) begin n_fail++; $display("FAIL rr_cycle: grant=%0d cyc=%b expected %0d %b", o_grant, owb_cyc, e_grant, e_cyc); end
            g = int'(o_grant);
            if (g != last && (seq.size() > 0 || g != 3)) seq.push_back(g);
            last = g;
            if (g != 3 && cyc[g]) begin
                held++;
                if (held == 2) begin pend = 1; drop_g = g; held = 0; end
            end
            tick();
            if (restore_g >= 0) begin cyc[restore_g] = 1; restore_g = -1; end
            if (pend) begin cyc[drop_g] = 0; restore_g = drop_g; pend = 0; end
        end
        n_checks++;
        if (seq.size() != 7) begin
            n_fail++; $display("FAIL rr_seq_len: got %0d entries expected 7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++; if (seq[i] != exp_seq[i]) begin n_fail++; $display("FAIL rr_seq[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]); end
            end
        end
    endtask

    task automatic test_burst();
        bit found;
        int acks, last;
        do_reset();
        cyc = 3'b010; stb = 3'b010; b8[1] = 1; found = 0; acks = 0; last = 3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_grant == 2'd1) begin found = 1; break; end
            tick();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL burst_grant_wait: got %0d expected 1", o_grant); end
        tick();
        cyc = 3'b111; stb = 3'b111; s_ack = 1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            model_expect();
            n_checks++; if (ack_o !== 3'b010 || ack_o !== e_ack) begin n_fail++; $display("FAIL burst_ack: got %b expected 010", ack_o); end
            n_checks++; if (o_grant !== 2'd1) begin n_fail++; $display("FAIL burst_hold: got %0d expected 1", o_grant); end
            n_checks++; if (owb_8_burst !== 1'b1 || owb_adr !== adr[1]) begin n_fail++; $display("FAIL burst_path: b8=%b adr=%h expected 1 %h", owb_8_burst, owb_adr, adr[1]); end
            if (ack_o[1] === 1'b1) acks++;
            tick();
        end
        s_ack = 0; stb[1] = 0;
        n_checks++; if (acks != 8) begin n_fail++; $display("FAIL burst_ack_count: got %0d expected 8", acks); end
        repeat (2) begin
            @(negedge clk);
            model_expect();
            n_checks++; if (o_grant !== 2'd1 || o_grant !== e_grant) begin n_fail++; $display("FAIL burst_no_preempt: got %0d expected 1", o_grant); end
            tick();
        end
        cyc[1] = 0;
        repeat (3) begin
            @(negedge clk);
            model_expect();
            n_checks++; if (o_grant !== e_grant) begin n_fail++; $display("FAIL burst_handoff_cycle: got %0d expected %0d", o_grant, e_grant); end
            last = int'(o_grant);
            tick();
        end
        n_checks++; if (last != 2) begin n_fail++; $display("FAIL burst_next_owner: got %0d expected 2", last); end
    endtask

    task automatic test_timeout();
        int gidx, pulses, errs, pulse_at;
        bit drop;
        gidx = 0; pulses = 0; errs = 0; pulse_at = -1; drop = 0;
        do_reset();
        cyc = 3'b100; stb = 3'b100;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            model_expect();
            if (o_grant == 2'd2) gidx++;
            n_checks++; if (o_timeout !== e_to || err_o !== e_err) begin n_fail++; $display("FAIL timeout_pulse: to=%b err=%b expected %b %b", o_timeout, err_o, e_to, e_err); end
            n_checks++; if (owb_cyc !== e_cyc || o_grant !== e_grant) begin n_fail++; $display("FAIL timeout_bus: cyc=%b grant=%0d expected %b %0d", owb_cyc, o_grant, e_cyc, e_grant); end
            if (o_timeout === 1'b1) begin pulses++; pulse_at = gidx; end
            if (err_o[2] === 1'b1) errs++;
            if (gidx == 10) drop = 1;
            tick();
            if (drop) begin cyc[2] = 0; stb[2] = 0; end
        end
        n_checks++; if (pulses != 1 || errs != 1) begin n_fail++; $display("FAIL timeout_once: pulses=%0d errs=%0d expected 1 1", pulses, errs); end
        n_checks++; if (pulse_at != TO + 2) begin n_fail++; $display("FAIL timeout_when: got grant-cycle %0d expected %0d", pulse_at, TO + 2); end
        n_checks++; if (o_grant !== 2'd3) begin n_fail++; $display("FAIL timeout_release: got %0d expected 3", o_grant); end
    endtask

    task automatic test_late_ack();
        int gidx;
        gidx = 0;
        do_reset();
        cyc = 3'b001; stb = 3'b001;
        for (int c = 0; c < 12 && gidx < 9; c++) begin
            @(negedge clk);
            model_expect();
            if (o_grant == 2'd0) gidx++;
            if (gidx == 5) begin
                n_checks++; if (ack_o !== 3'b001 || err_o !== 3'b000) begin n_fail++; $display("FAIL late_ack_fwd: ack=%b err=%b expected 001 000", ack_o, err_o); end
            end
            n_checks++; if (o_timeout !== 1'b0 || o_timeout !== e_to) begin n_fail++; $display("FAIL late_ack_no_timeout: got %b expected 0", o_timeout); end
            tick();
            s_ack = (gidx == 4);
        end
        n_checks++; if (owb_cyc !== 1'b1 || o_grant !== 2'd0) begin n_fail++; $display("FAIL late_ack_still_owned: cyc=%b grant=%0d expected 1 0", owb_cyc, o_grant); end
    endtask

    task automatic test_err_rty();
        int gidx;
        gidx = 0;
        do_reset();
        cyc = 3'b010; stb = 3'b010;
        for (int c = 0; c < 10 && gidx < 5; c++) begin
            @(negedge clk);
            model_expect();
            if (o_grant == 2'd1) gidx++;
            if (gidx == 2) begin
                n_checks++; if (err_o !== 3'b010 || ack_o !== 3'b000) begin n_fail++; $display("FAIL err_route: err=%b ack=%b expected 010 000", err_o, ack_o); end
            end
            if (gidx == 3) begin
                n_checks++; if (rty_o !== 3'b010 || err_o !== 3'b000) begin n_fail++; $display("FAIL rty_route: rty=%b err=%b expected 010 000", rty_o, err_o); end
            end
            if (gidx >= 4) begin
                n_checks++; if (o_grant !== 2'd1 || owb_cyc !== 1'b1) begin n_fail++; $display("FAIL err_rty_retain: grant=%0d cyc=%b expected 1 1", o_grant, owb_cyc); end
            end
            tick();
            cyc = (gidx >= 1) ? 3'b111 : 3'b010;
            s_err = (gidx == 1);
            s_rty = (gidx == 2);
        end
        s_err = 0; s_rty = 0;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 0;
        do_reset();
        cyc = 3'b001; stb = 3'b001;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_grant == 2'd0 && owb_cyc === 1'b1) begin found = 1; break; end
            tick();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL areset_pre_grant: grant=%0d cyc=%b expected 0 1", o_grant, owb_cyc); end
        @(posedge clk);
        model_step();
        #3 rst_n = 0;
        #1;
        n_checks++; if (owb_cyc !== 1'b0 || owb_stb !== 1'b0) begin n_fail++; $display("FAIL areset_drop: cyc=%b stb=%b expected 0 0", owb_cyc, owb_stb); end
        n_checks++; if (o_grant !== 2'd3) begin n_fail++; $display("FAIL areset_grant: got %0d expected 3", o_grant); end
        model_reset();
        cyc = 3'b100; stb = 3'b100;
        @(posedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            model_expect();
            n_checks++; if (o_grant !== e_grant) begin n_fail++; $display("FAIL areset_cycle: got %0d expected %0d", o_grant, e_grant); end
            if (o_grant != 2'd3) break;
            tick();
        end
        n_checks++; if (o_grant !== 2'd2) begin n_fail++; $display("FAIL areset_regrant: got %0d expected 2", o_grant); end
    endtask

    task automatic test_random();
        int own;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            model_expect();
            n_checks++;
            if (o_grant !== e_grant || owb_cyc !== e_cyc || owb_stb !== e_stb || o_timeout !== e_to) begin
                n_fail++;
                $display("FAIL rand_ctl @%0d: grant=%0d cyc=%b stb=%b to=%b expected %0d %b %b %b",
                         c, o_grant, owb_cyc, owb_stb, o_timeout, e_grant, e_cyc, e_stb, e_to);
            end
            n_checks++;
            if (ack_o !== e_ack || err_o !== e_err || rty_o !== e_rty) begin
                n_fail++;
                $display("FAIL rand_resp @%0d: ack=%b err=%b rty=%b expected %b %b %b",
                         c, ack_o, err_o, rty_o, e_ack, e_err, e_rty);
            end
            if (e_cyc) begin
                own = int'(e_grant);
                n_checks++;
                if (owb_adr !== adr[own] || owb_o_dat !== dat[own] || owb_sel !== sel[own] ||
                    owb_we !== we[own] || owb_4_burst !== b4[own] || owb_8_burst !== b8[own]) begin
                    n_fail++;
                    $display("FAIL rand_path @%0d: adr=%h dat=%h sel=%b expected %h %h %b",
                             c, owb_adr, owb_o_dat, owb_sel, adr[own], dat[own], sel[own]);
                end
            end
            tick();
            for (int n = 0; n < 3; n++) begin
                if (cyc[n]) cyc[n] = ($urandom_range(0, 9) != 0);
                else        cyc[n] = ($urandom_range(0, 3) == 0);
                stb[n] = cyc[n] & 1'($urandom);
                we[n]  = 1'($urandom);
                b4[n]  = 1'($urandom);
                b8[n]  = 1'($urandom);
                adr[n] = 24'($urandom);
                dat[n] = 16'($urandom);
                sel[n] = 2'($urandom);
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_err = ($urandom_range(0, 15) == 0);
            s_rty = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        model_reset();
        test_reset();
        test_rr_order();
        test_burst();
        test_timeout();
        test_late_ack();
        test_err_rty();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
